// File: rtl/column_frame_loader_if.sv
// Configuration word stream from the controller plus frame-register outputs
// for one fabric column's frame loader.
interface column_frame_loader_if #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20
);
    logic [FrameBitsPerRow-1:0] WriteData_I;
    logic                       WriteStrobe_I;
    logic                       Ready_O;
    logic [FrameBitsPerRow-1:0] FrameData_O;
    logic [MaxFramesPerCol-1:0] FrameStrobe_O;
    logic                       Busy_O;
    logic                       Error_O;
    logic                       ErrorClear_I;

    modport master (
        output WriteData_I, WriteStrobe_I, ErrorClear_I,
        input  Ready_O, FrameData_O, FrameStrobe_O, Busy_O, Error_O
    );

    modport slave (
        input  WriteData_I, WriteStrobe_I, ErrorClear_I,
        output Ready_O, FrameData_O, FrameStrobe_O, Busy_O, Error_O
    );
endinterface

// File: rtl/column_frame_loader.sv
// Column-foot configuration stage: takes header/data word pairs addressed to
// this column and drives one frame word plus a one-hot latch strobe.
module column_frame_loader #(
    parameter logic [7:0] COLUMN_ID       = 8'd0,
    parameter int         MaxFramesPerCol = 20,
    parameter int         FrameBitsPerRow = 32,
    parameter int         StrobeCycles    = 1
) (
    input logic                CLK,
    input logic                resetn,
    column_frame_loader_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DATA   = 3'd1;
    localparam logic [2:0] SKIP   = 3'd2;
    localparam logic [2:0] SETUP  = 3'd3;
    localparam logic [2:0] STROBE = 3'd4;
    localparam logic [2:0] HOLD   = 3'd5;

    localparam logic [3:0]                 Marker     = 4'hA;
    localparam logic [3:0]                 StrobeLoad = 4'(StrobeCycles - 1);
    localparam logic [5:0]                 FrameLimit = 6'(MaxFramesPerCol);
    localparam logic [MaxFramesPerCol-1:0] StrobeOne  = MaxFramesPerCol'(1);

    logic [2:0]                 state;
    logic [2:0]                 state_next;
    logic [3:0]                 strobe_cnt;
    logic [4:0]                 frame_idx;
    logic [FrameBitsPerRow-1:0] word;
    logic                       accept;
    logic                       marker_ok;
    logic                       column_ok;
    logic                       frame_ok;
    logic                       err_set;

    assign word      = bus.WriteData_I;
    assign bus.Ready_O = (state == IDLE) || (state == DATA) || (state == SKIP);
    assign accept    = bus.WriteStrobe_I && bus.Ready_O;
    assign marker_ok = (word[31:28] == Marker);
    assign column_ok = (word[27:20] == COLUMN_ID);
    assign frame_ok  = ({1'b0, word[19:15]} < FrameLimit);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!marker_ok) begin
                        err_set = 1'b1;
                    end else if (!column_ok) begin
                        state_next = SKIP;
                    end else if (!frame_ok) begin
                        err_set    = 1'b1;
                        state_next = SKIP;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA:    if (accept) state_next = SETUP;
            SKIP:    if (accept) state_next = IDLE;
            SETUP:   state_next = STROBE;
            STROBE:  if (strobe_cnt == 4'd0) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            bus.Busy_O        <= 1'b0;
            bus.Error_O       <= 1'b0;
            bus.FrameData_O   <= '0;
            bus.FrameStrobe_O <= '0;
            frame_idx         <= '0;
            strobe_cnt        <= '0;
        end else begin
            state      <= state_next;
            bus.Busy_O <= (state_next != IDLE);

            if (err_set) begin
                bus.Error_O <= 1'b1;
            end else if (bus.ErrorClear_I) begin
                bus.Error_O <= 1'b0;
            end

            if (state == IDLE && state_next == DATA) begin
                frame_idx <= word[19:15];
            end

            if (state == DATA && accept) begin
                bus.FrameData_O <= word;
            end

            // Strobe register is loaded on STROBE entry and cleared on exit, so it never glitches.
            if (state == SETUP) begin
                bus.FrameStrobe_O <= StrobeOne << frame_idx;
                strobe_cnt        <= StrobeLoad;
            end else if (state == STROBE) begin
                if (strobe_cnt == 4'd0) begin
                    bus.FrameStrobe_O <= '0;
                end else begin
                    strobe_cnt <= strobe_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/column_frame_loader.md
Name: column_frame_loader

Overview:
- Configuration-path stage at the foot of a fabric column, directly upstream of that column's terminal tiles (S_term_DSP and tiles above it).
- Consumes the serialised bitstream word stream from the configuration controller.
- Filters words addressed to its own column and presents one 32-bit frame word on FrameData_O.
- Pulses exactly one FrameStrobe_O bit so the column's frame registers latch that word.

Parameters:
- COLUMN_ID, 0, 8-bit column index this instance answers to.
- MaxFramesPerCol, 20, number of frame strobe lines and the exclusive upper bound on the frame index.
- FrameBitsPerRow, 32, frame word width; fixed at 32 (header format depends on it).
- StrobeCycles, 1, width of the FrameStrobe_O pulse in clock cycles; legal range 1..15.

Ports:
- CLK  in  1  configuration clock.
- resetn  in  1  asynchronous active-low reset.
- WriteData_I  in  32  bitstream word (header or data).
- WriteStrobe_I  in  1  word valid.
- Ready_O  out  1  word accepted when WriteStrobe_I && Ready_O at a rising edge.
- FrameData_O  out  32  frame data to column frame registers.
- FrameStrobe_O  out  MaxFramesPerCol  one-hot frame latch strobe.
- Busy_O  out  1  high in any state other than IDLE.
- Error_O  out  1  sticky protocol error.
- ErrorClear_I  in  1  synchronous clear of Error_O.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Port names are CLK and resetn.
  - resetn low forces state IDLE, FrameData_O=0, FrameStrobe_O=0, Error_O=0, Busy_O=0.
  - Ready_O is 1 while in IDLE, including during reset.
  - Reset mid-sequence aborts it; no strobe is emitted afterwards.
- Header format:
  - [31:28] = 4'hA marker.
  - [27:20] = column.
  - [19:15] = frame index.
  - [14:0] ignored.
- States: IDLE, DATA, SKIP, SETUP, STROBE, HOLD.
  - Ready_O = 1 in IDLE, DATA, SKIP; 0 in SETUP, STROBE, HOLD.
- IDLE, header accepted:
  - Marker != A: set Error, stay IDLE.
  - Marker ok, column != COLUMN_ID: go SKIP.
  - Marker ok, column match, frame >= MaxFramesPerCol: set Error, go SKIP.
  - Otherwise: latch frame index, go DATA.
- SKIP: next accepted word is dropped; go IDLE. FrameData_O and FrameStrobe_O are unchanged.
- DATA: accepted word is registered into FrameData_O at that edge; go SETUP.
- SETUP: one cycle; data stable, strobe low; go STROBE.
- STROBE:
  - FrameStrobe_O[idx]=1, all other bits 0, for exactly StrobeCycles cycles.
  - Counter is 4 bits and loaded on entry.
  - Then go HOLD.
- HOLD: one cycle; strobe low, data held; go IDLE.
- Latency: data word accepted at edge k.
  - FrameData_O valid after edge k.
  - Strobe high after edges k+1 .. k+StrobeCycles.
  - Ready_O returns high after edge k+StrobeCycles+2.
- FrameData_O holds its value until the next accepted DATA word; it is never cleared except by reset.
- FrameStrobe_O is registered and glitch-free; at most one bit is high in any cycle.
- WriteStrobe_I while Ready_O=0: ignored, not buffered. Upstream must hold the word.
- Error:
  - Error_O rises the cycle after the offending header.
  - ErrorClear_I clears it on the next edge.
  - Simultaneous set and clear: set wins.
- Busy_O = (state != IDLE), registered with state.

Test Plan:
- COLUMN_ID=3: header 0xA0318000 (col 3, frame 3), data 0xDEADBEEF -> FrameData_O=0xDEADBEEF after the data edge; FrameStrobe_O=0x00008 for exactly 1 cycle, 2 cycles later; Ready_O low for 3 cycles.
- Header 0xA0500000 (col 5) then data 0x12345678 -> word dropped; FrameData_O keeps its prior value; FrameStrobe_O stays 0; Error_O=0.
- Header 0x50318000 (bad marker) -> Error_O=1 next cycle, state IDLE. Then ErrorClear_I=1 together with another bad header -> Error_O stays 1. ErrorClear_I alone -> Error_O=0.
- Header with frame index 20 (MaxFramesPerCol=20), column match -> Error_O=1; following data word dropped; no strobe.
- StrobeCycles=4, WriteStrobe_I held high throughout a sequence -> strobe high exactly 4 cycles; no word accepted while Ready_O=0; next header accepted the first cycle back in IDLE.
- resetn asserted during STROBE -> FrameStrobe_O=0 and FrameData_O=0 immediately (asynchronous); after release, state IDLE, Ready_O=1.
